// File: rtl/updown_counter_mod.sv
// updown_counter_mod: up/down counter with run-time modulus, programmable
// step, parallel load and wrap-or-saturate boundary handling.
module updown_counter_mod #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      STEP_W    = 4,
  parameter bit               SATURATE  = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              En,
  input  logic              Down,
  input  logic              Load,
  input  logic [WIDTH-1:0]  LoadVal,
  input  logic [WIDTH-1:0]  Limit,
  input  logic [STEP_W-1:0] Step,
  input  logic              ClrFlag,
  output logic [WIDTH-1:0]  q,
  output logic              Wrap,
  output logic              Flag,
  output logic              AtMax,
  output logic              AtZero
);

  localparam int unsigned W1 = WIDTH + 1;
  localparam logic [W1-1:0] ONE = 1;

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_r;
  logic             flag_r;
  logic             evt;

  logic [W1-1:0]    q1;
  logic [W1-1:0]    lim1;
  logic [W1-1:0]    stp1;
  logic [W1-1:0]    s;
  logic [W1-1:0]    sum;
  logic [WIDTH-1:0] dif;
  logic [WIDTH-1:0] up_wr;
  logic [WIDTH-1:0] dn_wr;
  logic [WIDTH-1:0] ld_cl;

  // One extra bit so q + s never aliases modulo 2^WIDTH.
  assign q1    = {1'b0, q_r};
  assign lim1  = {1'b0, Limit};
  assign stp1  = {{(W1-STEP_W){1'b0}}, Step};
  assign s     = (stp1 > lim1) ? lim1 : stp1;
  assign sum   = q1 + s;
  assign dif   = WIDTH'(q1 - s);
  assign up_wr = WIDTH'(sum - (lim1 + ONE));
  assign dn_wr = WIDTH'(q1 + lim1 + ONE - s);
  assign ld_cl = (LoadVal > Limit) ? Limit : LoadVal;

  always_comb begin
    q_nxt = q_r;
    evt   = 1'b0;
    if (Load) begin
      q_nxt = ld_cl;
    end else if (En) begin
      if (q1 > lim1) begin
        q_nxt = Limit;
      end else if (!Down) begin
        if (sum <= lim1) begin
          q_nxt = sum[WIDTH-1:0];
        end else begin
          evt   = 1'b1;
          q_nxt = SATURATE ? Limit : up_wr;
        end
      end else begin
        if (q1 >= s) begin
          q_nxt = dif;
        end else begin
          evt   = 1'b1;
          q_nxt = SATURATE ? '0 : dn_wr;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      q_r    <= RESET_VAL;
      wrap_r <= 1'b0;
      flag_r <= 1'b0;
    end else begin
      q_r    <= q_nxt;
      wrap_r <= evt;
      if (evt)
        flag_r <= 1'b1;
      else if (ClrFlag)
        flag_r <= 1'b0;
    end
  end

  assign q      = q_r;
  assign Wrap   = wrap_r;
  assign Flag   = flag_r;
  assign AtMax  = (q_r == Limit);
  assign AtZero = (q_r == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// tb_updown_counter_mod: scoreboard bench for updown_counter_mod,
// one wrap-mode and one saturate-mode instance on shared stimulus.
module tb_updown_counter_mod;

  typedef struct {
    bit rst, en, dn, ld, clr;
    logic [7:0] lv, lim;
    logic [3:0] st;
    bit sel;
    logic [7:0] q;
    logic w, f;
  } vec_t;

  typedef struct {
    bit sel;
    logic [7:0] q, lim;
    logic w, f;
  } exp_t;

  typedef struct {
    logic [7:0] q;
    logic w, f, mx, z;
  } obs_t;

  logic       clock = 1'b0;
  logic       Reset = 1'b1;
  logic       En = 1'b0;
  logic       Down = 1'b0;
  logic       Load = 1'b0;
  logic [7:0] LoadVal = '0;
  logic [7:0] Limit = 8'd9;
  logic [3:0] Step = 4'd1;
  logic       ClrFlag = 1'b0;

  logic [7:0] qw, qs;
  logic       wrapw, flagw, mxw, zw;
  logic       wraps, flags, mxs, zs;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  updown_counter_mod #(
    .WIDTH(8), .STEP_W(4), .SATURATE(1'b0), .RESET_VAL(8'd0)
  ) dut_w (
    .clock(clock), .Reset(Reset), .En(En), .Down(Down),
    .Load(Load), .LoadVal(LoadVal), .Limit(Limit), .Step(Step),
    .ClrFlag(ClrFlag), .q(qw), .Wrap(wrapw), .Flag(flagw),
    .AtMax(mxw), .AtZero(zw)
  );

  updown_counter_mod #(
    .WIDTH(8), .STEP_W(4), .SATURATE(1'b1), .RESET_VAL(8'd0)
  ) dut_s (
    .clock(clock), .Reset(Reset), .En(En), .Down(Down),
    .Load(Load), .LoadVal(LoadVal), .Limit(Limit), .Step(Step),
    .ClrFlag(ClrFlag), .q(qs), .Wrap(wraps), .Flag(flags),
    .AtMax(mxs), .AtZero(zs)
  );

  function automatic vec_t mk(
    bit rst, bit en, bit dn, bit ld, bit clr,
    int lv, int lim, int st, bit sel,
    int q, bit w, bit f);
    vec_t v;
    v.rst = rst; v.en = en; v.dn = dn; v.ld = ld; v.clr = clr;
    v.lv = lv[7:0]; v.lim = lim[7:0]; v.st = st[3:0];
    v.sel = sel; v.q = q[7:0]; v.w = w; v.f = f;
    return v;
  endfunction

  function automatic obs_t obs(bit sel);
    obs_t o;
    if (sel) o = '{q: qs, w: wraps, f: flags, mx: mxs, z: zs};
    else     o = '{q: qw, w: wrapw, f: flagw, mx: mxw, z: zw};
    return o;
  endfunction

  task automatic drive(input vec_t v);
    Reset = v.rst; En = v.en; Down = v.dn; Load = v.ld;
    ClrFlag = v.clr; LoadVal = v.lv; Limit = v.lim; Step = v.st;
    sbq.push_back('{sel: v.sel, q: v.q, lim: v.lim, w: v.w, f: v.f});
  endtask

  task automatic test_reset();
    vec_t v[$]; exp_t e; obs_t o;
    v.push_back(mk(1,0,0,0,0, 0,9,1, 0, 0,0,0));
    v.push_back(mk(1,0,0,0,0, 0,9,1, 1, 0,0,0));
    v.push_back(mk(0,0,0,0,0, 0,9,1, 0, 0,0,0));
    v.push_back(mk(0,0,0,0,0, 0,9,1, 1, 0,0,0));
    foreach (v[i]) begin
      drive(v[i]); @(posedge clock); #1;
      e = sbq.pop_front(); o = obs(e.sel); checks++;
      if ({o.q,o.w,o.f,o.mx,o.z} !==
          {e.q,e.w,e.f,e.q==e.lim,e.q==8'd0}) begin
        errors++;
        $display("FAIL reset[%0d] got q=%0d w=%b f=%b mx=%b z=%b exp q=%0d w=%b f=%b",
                 i, o.q, o.w, o.f, o.mx, o.z, e.q, e.w, e.f);
      end
    end
  endtask

  task automatic test_wrap_up();
    vec_t v[$]; exp_t e; obs_t o;
    for (int k = 1; k <= 12; k++)
      v.push_back(mk(0,1,0,0,0, 0,9,1, 0, k%10, k==10, k>=10));
    v.push_back(mk(0,0,0,0,1, 0,9,1, 0, 2,0,0));
    foreach (v[i]) begin
      drive(v[i]); @(posedge clock); #1;
      e = sbq.pop_front(); o = obs(e.sel); checks++;
      if ({o.q,o.w,o.f,o.mx,o.z} !==
          {e.q,e.w,e.f,e.q==e.lim,e.q==8'd0}) begin
        errors++;
        $display("FAIL wrap_up[%0d] got q=%0d w=%b f=%b mx=%b z=%b exp q=%0d w=%b f=%b",
                 i, o.q, o.w, o.f, o.mx, o.z, e.q, e.w, e.f);
      end
    end
  endtask

  task automatic test_wrap_down();
    vec_t v[$]; exp_t e; obs_t o;
    v.push_back(mk(0,0,1,1,0, 1,9,3, 0, 1,0,0));
    v.push_back(mk(0,1,1,0,0, 0,9,3, 0, 8,1,1));
    v.push_back(mk(0,1,1,0,0, 0,9,3, 0, 5,0,1));
    v.push_back(mk(0,1,1,0,0, 0,9,3, 0, 2,0,1));
    v.push_back(mk(0,1,1,0,0, 0,9,3, 0, 9,1,1));
    foreach (v[i]) begin
      drive(v[i]); @(posedge clock); #1;
      e = sbq.pop_front(); o = obs(e.sel); checks++;
      if ({o.q,o.w,o.f,o.mx,o.z} !==
          {e.q,e.w,e.f,e.q==e.lim,e.q==8'd0}) begin
        errors++;
        $display("FAIL wrap_down[%0d] got q=%0d w=%b f=%b mx=%b z=%b exp q=%0d w=%b f=%b",
                 i, o.q, o.w, o.f, o.mx, o.z, e.q, e.w, e.f);
      end
    end
  endtask

  task automatic test_saturate();
    vec_t v[$]; exp_t e; obs_t o;
    v.push_back(mk(0,0,0,1,1, 190,200,15, 1, 190,0,0));
    for (int k = 0; k < 4; k++)
      v.push_back(mk(0,1,0,0,0, 0,200,15, 1, 200,1,1));
    v.push_back(mk(0,1,1,1,0, 5,200,15, 1, 5,0,1));
    for (int k = 0; k < 3; k++)
      v.push_back(mk(0,1,1,0,0, 0,200,15, 1, 0,1,1));
    v.push_back(mk(0,0,1,0,0, 0,200,15, 1, 0,0,1));
    foreach (v[i]) begin
      drive(v[i]); @(posedge clock); #1;
      e = sbq.pop_front(); o = obs(e.sel); checks++;
      if ({o.q,o.w,o.f,o.mx,o.z} !==
          {e.q,e.w,e.f,e.q==e.lim,e.q==8'd0}) begin
        errors++;
        $display("FAIL saturate[%0d] got q=%0d w=%b f=%b mx=%b z=%b exp q=%0d w=%b f=%b",
                 i, o.q, o.w, o.f, o.mx, o.z, e.q, e.w, e.f);
      end
    end
  endtask

  task automatic test_load_limit();
    vec_t v[$]; exp_t e; obs_t o;
    v.push_back(mk(0,1,0,1,0, 250,100,1, 0, 100,0,1));
    v.push_back(mk(0,1,0,1,0, 250,100,1, 1, 100,0,1));
    v.push_back(mk(0,1,0,0,0, 0,50,1, 0, 50,0,1));
    v.push_back(mk(0,0,0,0,0, 0,50,1, 1, 50,0,1));
    foreach (v[i]) begin
      drive(v[i]); @(posedge clock); #1;
      e = sbq.pop_front(); o = obs(e.sel); checks++;
      if ({o.q,o.w,o.f,o.mx,o.z} !==
          {e.q,e.w,e.f,e.q==e.lim,e.q==8'd0}) begin
        errors++;
        $display("FAIL load_limit[%0d] got q=%0d w=%b f=%b mx=%b z=%b exp q=%0d w=%b f=%b",
                 i, o.q, o.w, o.f, o.mx, o.z, e.q, e.w, e.f);
      end
    end
  endtask

  task automatic test_simultaneous();
    vec_t v[$]; exp_t e; obs_t o;
    v.push_back(mk(0,0,0,1,0, 9,9,1, 0, 9,0,1));
    v.push_back(mk(1,1,0,1,0, 5,9,1, 0, 0,0,0));
    v.push_back(mk(0,0,0,1,0, 9,9,1, 0, 9,0,0));
    v.push_back(mk(0,1,0,0,1, 0,9,1, 0, 0,1,1));
    v.push_back(mk(1,1,0,0,0, 0,9,1, 0, 0,0,0));
    v.push_back(mk(0,1,0,0,0, 0,9,0, 0, 0,0,0));
    v.push_back(mk(0,1,0,0,0, 0,0,5, 0, 0,0,0));
    v.push_back(mk(0,1,1,0,0, 0,0,5, 0, 0,0,0));
    foreach (v[i]) begin
      drive(v[i]); @(posedge clock); #1;
      e = sbq.pop_front(); o = obs(e.sel); checks++;
      if ({o.q,o.w,o.f,o.mx,o.z} !==
          {e.q,e.w,e.f,e.q==e.lim,e.q==8'd0}) begin
        errors++;
        $display("FAIL simultaneous[%0d] got q=%0d w=%b f=%b mx=%b z=%b exp q=%0d w=%b f=%b",
                 i, o.q, o.w, o.f, o.mx, o.z, e.q, e.w, e.f);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_load_limit();
    test_simultaneous();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
